// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
package router_pkg;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam logic [ADDR_W-1:0] ILLEGAL_ADDR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HEADER,
    PAYLOAD,
    PARITY,
    GAP
  } state_t;

  // Header byte as the router expects it: length in the upper bits, port in the lower.
  function automatic logic [LEN_W+ADDR_W-1:0] pack_header(input logic [LEN_W-1:0]  len,
                                                           input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_tx_buf.sv
// Payload staging buffer: one write port, one combinational read port, no flags.
module tx_payload_buf
  import router_pkg::*;
#(
  parameter int AW = LEN_W
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: buffers a payload, then sends header, payload,
// parity and a gap window in which the router parity-error flag is collected.
module router_pkt_tx #(
  parameter int LEN_W      = 6,
  parameter int GAP_CYCLES = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       dest_addr,
  input  logic [LEN_W-1:0] payload_len,
  input  logic             corrupt_parity,
  input  logic [7:0]       pl_data,
  input  logic             pl_valid,
  output logic             pl_ready,
  input  logic             busy,
  input  logic             err,
  output logic [7:0]       data_out,
  output logic             pkt_valid,
  output logic             tx_active,
  output logic             tx_done,
  output logic             tx_err,
  output logic             cfg_err
);
  import router_pkg::*;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q, len_nxt;
  logic [1:0]       addr_q, addr_nxt;
  logic             corrupt_q, corrupt_nxt;
  logic [LEN_W-1:0] wr_ptr, wr_nxt;
  logic [LEN_W-1:0] rd_ptr, rd_nxt;
  logic [7:0]       acc, acc_nxt;
  logic [7:0]       gap_cnt, gap_nxt;
  logic             err_seen, err_seen_nxt;
  logic [7:0]       data_nxt;
  logic             pkt_valid_nxt, tx_done_nxt, tx_err_nxt, cfg_err_nxt;
  logic             buf_we;
  logic [7:0]       rd_data;

  tx_payload_buf #(.AW(LEN_W)) u_buf (
    .clock   (clock),
    .we      (buf_we),
    .wr_addr (wr_ptr),
    .wr_data (pl_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  assign pl_ready  = (state == LOAD);
  assign tx_active = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      len_q     <= '0;
      addr_q    <= '0;
      corrupt_q <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      acc       <= '0;
      gap_cnt   <= '0;
      err_seen  <= 1'b0;
      data_out  <= '0;
      pkt_valid <= 1'b0;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      len_q     <= len_nxt;
      addr_q    <= addr_nxt;
      corrupt_q <= corrupt_nxt;
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      acc       <= acc_nxt;
      gap_cnt   <= gap_nxt;
      err_seen  <= err_seen_nxt;
      data_out  <= data_nxt;
      pkt_valid <= pkt_valid_nxt;
      tx_done   <= tx_done_nxt;
      tx_err    <= tx_err_nxt;
      cfg_err   <= cfg_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    len_nxt       = len_q;
    addr_nxt      = addr_q;
    corrupt_nxt   = corrupt_q;
    wr_nxt        = wr_ptr;
    rd_nxt        = rd_ptr;
    acc_nxt       = acc;
    gap_nxt       = gap_cnt;
    err_seen_nxt  = err_seen;
    data_nxt      = data_out;
    pkt_valid_nxt = pkt_valid;
    tx_done_nxt   = 1'b0;
    tx_err_nxt    = 1'b0;
    cfg_err_nxt   = 1'b0;
    buf_we        = 1'b0;
    case (state)
      IDLE: begin
        data_nxt      = '0;
        pkt_valid_nxt = 1'b0;
        if (start) begin
          if (dest_addr == ILLEGAL_ADDR || payload_len == '0) begin
            cfg_err_nxt = 1'b1;
          end else begin
            len_nxt      = payload_len;
            addr_nxt     = dest_addr;
            corrupt_nxt  = corrupt_parity;
            acc_nxt      = pack_header(payload_len, dest_addr);
            wr_nxt       = '0;
            rd_nxt       = '0;
            err_seen_nxt = 1'b0;
            state_nxt    = LOAD;
          end
        end
      end
      LOAD: begin
        if (pl_valid) begin
          buf_we  = 1'b1;
          acc_nxt = acc ^ pl_data;
          wr_nxt  = wr_ptr + LEN_W'(1);
          if (wr_ptr == len_q - LEN_W'(1)) begin
            data_nxt      = pack_header(len_q, addr_q);
            pkt_valid_nxt = 1'b1;
            state_nxt     = HEADER;
          end
        end
      end
      HEADER: begin
        if (!busy) begin
          data_nxt  = rd_data;
          rd_nxt    = rd_ptr + LEN_W'(1);
          state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        // rd_ptr already points past the byte on data_out, so equality means the last one is showing.
        if (!busy) begin
          if (rd_ptr == len_q) begin
            data_nxt      = corrupt_q ? ~acc : acc;
            pkt_valid_nxt = 1'b0;
            state_nxt     = PARITY;
          end else begin
            data_nxt = rd_data;
            rd_nxt   = rd_ptr + LEN_W'(1);
          end
        end
      end
      PARITY: begin
        if (!busy) begin
          data_nxt     = '0;
          gap_nxt      = '0;
          err_seen_nxt = 1'b0;
          state_nxt    = GAP;
        end
      end
      GAP: begin
        err_seen_nxt = err_seen | err;
        gap_nxt      = gap_cnt + 8'd1;
        if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
          tx_done_nxt = 1'b1;
          tx_err_nxt  = err_seen | err;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Table-driven bench for router_pkt_tx with an output-byte scoreboard.
module tb_router_pkt_tx;

  localparam int GAP = 3;

  typedef struct {
    logic [1:0] addr;
    logic [5:0] len;
    bit         corrupt;
    bit         stall;
    bit         toggle;
    int         err_cycle;
    int         reset_idx;
    bit         exp_cfg_err;
    bit         exp_tx_err;
    logic [7:0] exp_hdr;
  } vec_t;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dest_addr = '0;
  logic [5:0] payload_len = '0;
  logic       corrupt_parity = 1'b0;
  logic [7:0] pl_data = '0;
  logic       pl_valid = 1'b0;
  logic       busy = 1'b0;
  logic       err = 1'b0;
  logic       pl_ready, pkt_valid, tx_active, tx_done, tx_err, cfg_err;
  logic [7:0] data_out;

  int total = 0;
  int bad = 0;
  logic [8:0] exp_q[$];
  vec_t vecs[9];

  router_pkt_tx #(.LEN_W(6), .GAP_CYCLES(GAP)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .start          (start),
    .dest_addr      (dest_addr),
    .payload_len    (payload_len),
    .corrupt_parity (corrupt_parity),
    .pl_data        (pl_data),
    .pl_valid       (pl_valid),
    .pl_ready       (pl_ready),
    .busy           (busy),
    .err            (err),
    .data_out       (data_out),
    .pkt_valid      (pkt_valid),
    .tx_active      (tx_active),
    .tx_done        (tx_done),
    .tx_err         (tx_err),
    .cfg_err        (cfg_err)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, ".data_out"},  32'(data_out),  32'd0);
    check_output({tag, ".pkt_valid"}, 32'(pkt_valid), 32'd0);
    check_output({tag, ".pl_ready"},  32'(pl_ready),  32'd0);
    check_output({tag, ".tx_active"}, 32'(tx_active), 32'd0);
    check_output({tag, ".tx_done"},   32'(tx_done),   32'd0);
    check_output({tag, ".tx_err"},    32'(tx_err),    32'd0);
    check_output({tag, ".cfg_err"},   32'(cfg_err),   32'd0);
  endtask

  task automatic apply_stimulus(input vec_t v);
    logic [7:0] bytes [64];
    logic [7:0] par;
    int shown;
    int stall_left;

    @(negedge clock);
    dest_addr      = v.addr;
    payload_len    = v.len;
    corrupt_parity = v.corrupt;
    start          = 1'b1;
    @(negedge clock);
    start = 1'b0;

    if (v.exp_cfg_err) begin
      check_output("cfg_err_pulse", 32'(cfg_err), 32'd1);
      check_output("cfg_pl_ready",  32'(pl_ready), 32'd0);
      check_output("cfg_pkt_valid", 32'(pkt_valid), 32'd0);
      check_output("cfg_tx_active", 32'(tx_active), 32'd0);
      @(negedge clock);
      check_output("cfg_err_clear", 32'(cfg_err), 32'd0);
      return;
    end

    check_output("load_tx_active", 32'(tx_active), 32'd1);
    check_output("load_pl_ready",  32'(pl_ready),  32'd1);

    par = v.exp_hdr;
    exp_q.push_back({1'b1, v.exp_hdr});
    for (int i = 0; i < int'(v.len); i++) begin
      bytes[i] = (v.len <= 6'd4) ? 8'(8'h11 * (i + 1)) : 8'($urandom);
      if (v.toggle) begin
        pl_valid = 1'b0;
        @(negedge clock);
        check_output("load_gap_pkt_valid", 32'(pkt_valid), 32'd0);
      end
      pl_valid = 1'b1;
      pl_data  = bytes[i];
      exp_q.push_back({1'b1, bytes[i]});
      par = par ^ bytes[i];
      @(negedge clock);
      if (i < int'(v.len) - 1)
        check_output("load_pkt_valid", 32'(pkt_valid), 32'd0);
    end
    pl_valid = 1'b0;
    check_output("header_pl_ready", 32'(pl_ready), 32'd0);
    exp_q.push_back({1'b0, v.corrupt ? ~par : par});

    // Compare the byte on the wire each cycle; it only leaves the queue when busy lets it go.
    shown = 0;
    stall_left = v.stall ? 3 : 0;
    while (exp_q.size() > 0) begin
      if (v.reset_idx == shown) begin
        resetn = 1'b0;
        @(negedge clock);
        check_idle_outputs("midreset");
        resetn = 1'b1;
        exp_q.delete();
        return;
      end
      busy = (stall_left > 0 && shown == 2);
      check_output("stream", 32'({pkt_valid, data_out}), 32'(exp_q[0]));
      if (busy) stall_left--;
      else begin
        void'(exp_q.pop_front());
        shown++;
      end
      @(negedge clock);
    end
    busy = 1'b0;

    for (int g = 1; g <= GAP; g++) begin
      check_output("gap_data_out",  32'(data_out),  32'd0);
      check_output("gap_pkt_valid", 32'(pkt_valid), 32'd0);
      check_output("gap_tx_done",   32'(tx_done),   32'd0);
      err = (g == v.err_cycle);
      @(negedge clock);
    end
    err = 1'b0;
    check_output("tx_done_pulse", 32'(tx_done),   32'd1);
    check_output("tx_err",        32'(tx_err),    32'(v.exp_tx_err));
    check_output("done_tx_active", 32'(tx_active), 32'd0);
    @(negedge clock);
    check_output("tx_done_clear", 32'(tx_done), 32'd0);
  endtask

  initial begin
    vecs[0] = '{addr:2'd1, len:6'd3,  corrupt:0, stall:0, toggle:0, err_cycle:0, reset_idx:-1,
                exp_cfg_err:0, exp_tx_err:0, exp_hdr:8'h0D};
    vecs[1] = '{addr:2'd1, len:6'd3,  corrupt:0, stall:1, toggle:0, err_cycle:0, reset_idx:-1,
                exp_cfg_err:0, exp_tx_err:0, exp_hdr:8'h0D};
    vecs[2] = '{addr:2'd1, len:6'd3,  corrupt:1, stall:0, toggle:0, err_cycle:2, reset_idx:-1,
                exp_cfg_err:0, exp_tx_err:1, exp_hdr:8'h0D};
    vecs[3] = '{addr:2'd3, len:6'd5,  corrupt:0, stall:0, toggle:0, err_cycle:0, reset_idx:-1,
                exp_cfg_err:1, exp_tx_err:0, exp_hdr:8'h00};
    vecs[4] = '{addr:2'd0, len:6'd0,  corrupt:0, stall:0, toggle:0, err_cycle:0, reset_idx:-1,
                exp_cfg_err:1, exp_tx_err:0, exp_hdr:8'h00};
    vecs[5] = '{addr:2'd2, len:6'd63, corrupt:0, stall:0, toggle:1, err_cycle:0, reset_idx:-1,
                exp_cfg_err:0, exp_tx_err:0, exp_hdr:8'hFE};
    vecs[6] = '{addr:2'd1, len:6'd3,  corrupt:0, stall:0, toggle:0, err_cycle:0, reset_idx:2,
                exp_cfg_err:0, exp_tx_err:0, exp_hdr:8'h0D};
    vecs[7] = '{addr:2'd1, len:6'd3,  corrupt:0, stall:0, toggle:0, err_cycle:0, reset_idx:-1,
                exp_cfg_err:0, exp_tx_err:0, exp_hdr:8'h0D};
    vecs[8] = '{addr:2'd0, len:6'd1,  corrupt:0, stall:0, toggle:0, err_cycle:3, reset_idx:-1,
                exp_cfg_err:0, exp_tx_err:1, exp_hdr:8'h04};

    resetn = 1'b0;
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    resetn = 1'b1;

    for (int k = 0; k < 9; k++) begin
      $display("[TB] vector %0d: addr=%0d len=%0d", k, vecs[k].addr, vecs[k].len);
      apply_stimulus(vecs[k]);
    end

    // Start must be ignored while a packet is in flight.
    @(negedge clock);
    dest_addr = 2'd1; payload_len = 6'd3; corrupt_parity = 1'b0; start = 1'b1;
    @(negedge clock);
    dest_addr = 2'd3; payload_len = 6'd0;
    @(negedge clock);
    start = 1'b0;
    check_output("busy_start_no_cfg_err", 32'(cfg_err), 32'd0);
    check_output("busy_start_still_load", 32'(pl_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
